// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALT   = 2'd1,
      ST_RESUME = 2'd2
   } state_e;

   localparam int CNT_W_DEF = 32;
   localparam int REG_W_DEF = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_stat_counter.sv
// Wrapping statistics counter with increment enable; a synchronous clear wins over an increment.
module stat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: drives PC and pipeline-register enables/clears,
// sequences halt/resume on the retiring lock instruction, and keeps statistics.
//
// state  | meaning
// RUN    | normal operation; a lock instruction in WB freezes the pipe and halts
// HALT   | pipe frozen; waiting for a fresh press of the go button
// RESUME | one advancing cycle that lets the lock instruction retire
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REG_W = REG_W_DEF
) (
   input  logic             in_CLK,
   input  logic             in_CLR_N,
   input  logic [REG_W-1:0] in_id_rs,
   input  logic [REG_W-1:0] in_id_rt,
   input  logic             in_id_use_rs,
   input  logic             in_id_use_rt,
   input  logic [REG_W-1:0] in_ex_rd,
   input  logic             in_ex_memread,
   input  logic             in_ex_taken,
   input  logic             in_mem_busy,
   input  logic             in_wb_lock,
   input  logic             in_go,
   input  logic             in_cnt_clr,
   output logic             out_pc_en,
   output logic             out_ifid_en,
   output logic             out_idex_en,
   output logic             out_exmem_en,
   output logic             out_memwb_en,
   output logic             out_ifid_clr,
   output logic             out_idex_clr,
   output logic             out_halted,
   output logic [CNT_W-1:0] out_cycles,
   output logic [CNT_W-1:0] out_stalls,
   output logic [CNT_W-1:0] out_flushes
);

   state_e state_q, state_d;
   logic   go_q;
   logic   halted_q;
   logic   go_pulse;
   logic   freeze;
   logic   load_use;
   logic   sel_flush;
   logic   sel_stall;

   assign go_pulse = in_go & ~go_q;
   assign freeze   = (state_q == ST_HALT) || ((state_q == ST_RUN) && in_wb_lock);
   assign load_use = in_ex_memread && (in_ex_rd != '0) &&
                     ((in_id_use_rs && (in_id_rs == in_ex_rd)) ||
                      (in_id_use_rt && (in_id_rt == in_ex_rd)));

   assign sel_flush = !freeze && !in_mem_busy && in_ex_taken;
   assign sel_stall = !freeze && !in_mem_busy && !in_ex_taken && load_use;

   always_comb begin
      out_pc_en    = 1'b1;
      out_ifid_en  = 1'b1;
      out_idex_en  = 1'b1;
      out_exmem_en = 1'b1;
      out_memwb_en = 1'b1;
      out_ifid_clr = 1'b0;
      out_idex_clr = 1'b0;
      if (freeze || in_mem_busy) begin
         out_pc_en    = 1'b0;
         out_ifid_en  = 1'b0;
         out_idex_en  = 1'b0;
         out_exmem_en = 1'b0;
         out_memwb_en = 1'b0;
      end else if (sel_flush) begin
         out_ifid_clr = 1'b1;
         out_idex_clr = 1'b1;
      end else if (sel_stall) begin
         out_pc_en    = 1'b0;
         out_ifid_en  = 1'b0;
         out_idex_clr = 1'b1;
      end
   end

   // RESUME is left only on a cycle the pipe actually advances, so a busy
   // memory cannot swallow the lock instruction's retirement.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:    if (in_wb_lock)   state_d = ST_HALT;
         ST_HALT:   if (go_pulse)     state_d = ST_RESUME;
         ST_RESUME: if (!in_mem_busy) state_d = ST_RUN;
         default:                     state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge in_CLK or negedge in_CLR_N) begin
      if (!in_CLR_N) begin
         state_q  <= ST_RUN;
         go_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         go_q     <= in_go;
         halted_q <= (state_d == ST_HALT);
      end
   end

   assign out_halted = halted_q;

   stat_counter #(.W(CNT_W)) u_cycles (
      .clk   (in_CLK),
      .rst_n (in_CLR_N),
      .inc   (state_q != ST_HALT),
      .clr   (in_cnt_clr),
      .cnt   (out_cycles)
   );

   stat_counter #(.W(CNT_W)) u_stalls (
      .clk   (in_CLK),
      .rst_n (in_CLR_N),
      .inc   (sel_stall),
      .clr   (in_cnt_clr),
      .cnt   (out_stalls)
   );

   stat_counter #(.W(CNT_W)) u_flushes (
      .clk   (in_CLK),
      .rst_n (in_CLR_N),
      .inc   (sel_flush),
      .clr   (in_cnt_clr),
      .cnt   (out_flushes)
   );

endmodule
